dmem_resp: RTL and testbench

- Data-memory responder for the core's data SRAM port: the slave end of dat_a/dat_we/dat_wd/dat_re/dat_rd.
- Single-ported, byte-lane word memory with fixed 1-cycle read latency, because the core-side interface has no ready signal.
- Adds a host access port (testbench/debug loader) with a req/ack handshake. The host is serviced only in cycles where the core is idle.
- Sits beside the core at SoC top level, in place of the bare data SRAM.

---
 rtl/dmem_resp_pkg.sv | 28 ++
 rtl/dmem_bank.sv | 75 +++++++
 rtl/dmem_resp.sv | 119 +++++++++++
 tb/tb_dmem_resp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// dmem_resp shared types and helpers.
// Parity storage/check enabled by DMEM_RESP_PARITY_EN.
package dmem_resp_pkg;

  localparam int DEPTH_DEF  = 4096;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic {
    H_IDLE,
    H_ACK
  } host_st_t;

  function automatic logic [31:0] lane_mask(
    input logic [3:0]  en,
    input logic [31:0] d
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i+:8] = en[i] ? d[8*i+:8] : 8'h00;
    end
    return r;
  endfunction

  function automatic logic par8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_resp storage bank: byte-lane array, registered reads.
// Parity array present when DMEM_RESP_PARITY_EN is defined.
module dmem_bank
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn_i,
  input  logic [IW-1:0] idx_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wd_i,
  input  logic [3:0]    cre_i,
  input  logic          hre_i,
  output logic [31:0]   crd_o,
  output logic [31:0]   hrd_o,
  output logic          perr_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rword;
  logic [31:0] crd_q;
  logic [31:0] hrd_q;

  assign rword = mem_q[idx_i];

  // Byte-lane writes; array content is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[idx_i][8*i+:8] <= wd_i[8*i+:8];
    end
  end

  // Separate core/host read registers so each holds independently.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      crd_q <= '0;
      hrd_q <= '0;
    end else begin
      if (|cre_i) crd_q <= lane_mask(cre_i, rword);
      if (hre_i)  hrd_q <= rword;
    end
  end

  assign crd_o = crd_q;
  assign hrd_o = hrd_q;

`ifdef DMEM_RESP_PARITY_EN
  logic [3:0] par_q [DEPTH];
  logic [3:0] chk;
  logic [3:0] rpar;

  assign chk  = cre_i | {4{hre_i}};
  assign rpar = par_q[idx_i];

  // Parity bit follows its byte on every write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) par_q[idx_i][i] <= par8(wd_i[8*i+:8]);
    end
  end

  // Mismatch on any lane being read this cycle.
  always_comb begin
    perr_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (chk[i] && (par8(rword[8*i+:8]) != rpar[i])) perr_o = 1'b1;
    end
  end
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: core data SRAM slave plus idle-cycle host port.
// Optional parity: define DMEM_RESP_PARITY_EN.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] dat_a,
  input  logic [3:0]        dat_we,
  input  logic [31:0]       dat_wd,
  input  logic [3:0]        dat_re,
  output logic [31:0]       dat_rd,
  input  logic              hst_req,
  input  logic              hst_we,
  input  logic [ADDR_W-1:0] hst_a,
  input  logic [31:0]       hst_wd,
  output logic              hst_ack,
  output logic [31:0]       hst_rd,
  output logic              par_err
);

  localparam int IW = $clog2(DEPTH);

  host_st_t    st_q;
  logic        ack_q;
  logic        core_act;
  logic        hst_go;
  logic [IW-1:0] idx;
  logic [3:0]  we;
  logic [31:0] wd;
  logic [3:0]  cre;
  logic        hre;
  logic        perr;

  assign core_act = (|dat_we) | (|dat_re);
  assign hst_go   = (st_q == H_IDLE) & hst_req & ~core_act;

  assign idx = core_act ? dat_a[IW-1:0] : hst_a[IW-1:0];
  assign wd  = core_act ? dat_wd : hst_wd;

  // Accesses seen during reset are dropped.
  always_comb begin
    we  = 4'h0;
    cre = 4'h0;
    hre = 1'b0;
    if (rstn) begin
      if (core_act) begin
        we  = dat_we;
        cre = dat_re;
      end else if (hst_go) begin
        we  = hst_we ? 4'hF : 4'h0;
        hre = ~hst_we;
      end
    end
  end

  generate
    if (ADDR_W > IW) begin : g_alias
      logic unused_hi;
      assign unused_hi = ^{dat_a[ADDR_W-1:IW], hst_a[ADDR_W-1:IW]};
    end
  endgenerate

  dmem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk    (clk),
    .rstn_i (rstn),
    .idx_i  (idx),
    .we_i   (we),
    .wd_i   (wd),
    .cre_i  (cre),
    .hre_i  (hre),
    .crd_o  (dat_rd),
    .hrd_o  (hst_rd),
    .perr_o (perr)
  );

  // Host FSM: access in idle cycle, one-cycle ack, then back.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q  <= H_IDLE;
      ack_q <= 1'b0;
    end else begin
      unique case (st_q)
        H_IDLE: begin
          if (hst_go) begin
            st_q  <= H_ACK;
            ack_q <= 1'b1;
          end
        end
        H_ACK: begin
          st_q  <= H_IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign hst_ack = ack_q;

`ifdef DMEM_RESP_PARITY_EN
  logic par_err_q;

  // Sticky parity error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstn) par_err_q <= 1'b0;
    else if (perr) par_err_q <= 1'b1;
  end

  assign par_err = par_err_q;
`else
  logic unused_perr;
  assign unused_perr = perr;
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp.
// Parity scenario compiled in with DMEM_RESP_PARITY_EN.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;
  logic        hst_req;
  logic        hst_we;
  logic [15:0] hst_a;
  logic [31:0] hst_wd;
  logic        hst_ack;
  logic [31:0] hst_rd;
  logic        par_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_resp u_dut (
    .clk     (clk),
    .rstn    (rstn),
    .dat_a   (dat_a),
    .dat_we  (dat_we),
    .dat_wd  (dat_wd),
    .dat_re  (dat_re),
    .dat_rd  (dat_rd),
    .hst_req (hst_req),
    .hst_we  (hst_we),
    .hst_a   (hst_a),
    .hst_wd  (hst_wd),
    .hst_ack (hst_ack),
    .hst_rd  (hst_rd),
    .par_err (par_err)
  );

  task automatic core_idle();
    dat_we = 4'h0;
    dat_re = 4'h0;
    dat_wd = 32'h0;
  endtask

  // Host transaction with core idle; returns ack/rd seen after the access edge.
  task automatic host_op(input logic we, input logic [15:0] a,
                         input logic [31:0] d,
                         output logic ack, output logic [31:0] rd);
    hst_req = 1'b1;
    hst_we  = we;
    hst_a   = a;
    hst_wd  = d;
    @(negedge clk);
    ack = hst_ack;
    rd  = hst_rd;
    hst_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dat_rd !== 32'h0) begin errors++; $display("FAIL reset_dat_rd got=%h exp=0", dat_rd); end
    checks++; if (hst_rd !== 32'h0) begin errors++; $display("FAIL reset_hst_rd got=%h exp=0", hst_rd); end
    checks++; if (hst_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", hst_ack); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par got=%b exp=0", par_err); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_host();
    logic ack;
    logic [31:0] rd;
    host_op(1'b1, 16'h0010, 32'hDEADBEEF, ack, rd);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL hwr_ack got=%b exp=1", ack); end
    checks++; if (hst_ack !== 1'b0) begin errors++; $display("FAIL hwr_ack_len got=%b exp=0", hst_ack); end
    host_op(1'b0, 16'h0010, 32'h0, ack, rd);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL hrd_ack got=%b exp=1", ack); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL hrd_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_core_lanes();
    logic ack;
    logic [31:0] rd;
    dat_a = 16'h0010; dat_we = 4'b0010; dat_wd = 32'h0000AA00;
    @(negedge clk);
    dat_we = 4'h0; dat_re = 4'b1111;
    @(negedge clk);
    checks++; if (dat_rd !== 32'hDEADAAEF) begin errors++; $display("FAIL lane_full got=%h exp=deadaaef", dat_rd); end
    dat_re = 4'b0001;
    @(negedge clk);
    checks++; if (dat_rd !== 32'h000000EF) begin errors++; $display("FAIL lane_b0 got=%h exp=000000ef", dat_rd); end
    core_idle();
    host_op(1'b0, 16'h0010, 32'h0, ack, rd);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL lane_hrd got=%h exp=deadaaef", rd); end
    checks++; if (dat_rd !== 32'h000000EF) begin errors++; $display("FAIL dat_rd_hold got=%h exp=000000ef", dat_rd); end
  endtask

  task automatic test_rbw();
    logic ack;
    logic [31:0] rd;
    host_op(1'b1, 16'h0020, 32'h11223344, ack, rd);
    dat_a = 16'h0020; dat_we = 4'hF; dat_wd = 32'hFFFFFFFF; dat_re = 4'hF;
    @(negedge clk);
    checks++; if (dat_rd !== 32'h11223344) begin errors++; $display("FAIL rbw_old got=%h exp=11223344", dat_rd); end
    dat_we = 4'h0;
    @(negedge clk);
    checks++; if (dat_rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL rbw_new got=%h exp=ffffffff", dat_rd); end
    core_idle();
    @(negedge clk);
  endtask

  task automatic test_alias();
    logic ack;
    logic [31:0] rd;
    host_op(1'b1, 16'hF020, 32'hCAFEF00D, ack, rd);
    dat_a = 16'h0020; dat_re = 4'hF;
    @(negedge clk);
    checks++; if (dat_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL alias got=%h exp=cafef00d", dat_rd); end
    core_idle();
    @(negedge clk);
  endtask

  task automatic test_host_wait();
    int early;
    early = 0;
    dat_a = 16'h0020; dat_re = 4'hF;
    hst_req = 1'b1; hst_we = 1'b0; hst_a = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (hst_ack !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL wait_noack got=%0d acks exp=0", early); end
    core_idle();
    @(negedge clk);
    checks++; if (hst_ack !== 1'b1) begin errors++; $display("FAIL wait_ack got=%b exp=1", hst_ack); end
    checks++; if (hst_rd !== 32'hDEADAAEF) begin errors++; $display("FAIL wait_rd got=%h exp=deadaaef", hst_rd); end
    hst_req = 1'b0;
    @(negedge clk);
    checks++; if (hst_ack !== 1'b0) begin errors++; $display("FAIL wait_ack_drop got=%b exp=0", hst_ack); end
  endtask

  task automatic test_back_to_back();
    hst_req = 1'b1; hst_we = 1'b1; hst_a = 16'h0050; hst_wd = 32'h5555AAAA;
    @(negedge clk);
    checks++; if (hst_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got=%b exp=1", hst_ack); end
    hst_we = 1'b0;
    @(negedge clk);
    checks++; if (hst_ack !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b exp=0", hst_ack); end
    @(negedge clk);
    checks++; if (hst_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got=%b exp=1", hst_ack); end
    checks++; if (hst_rd !== 32'h5555AAAA) begin errors++; $display("FAIL b2b_rd got=%h exp=5555aaaa", hst_rd); end
    hst_req = 1'b0;
    @(negedge clk);
    dat_re = 4'hF; dat_a = 16'h0010;
    @(negedge clk);
    checks++; if (dat_rd !== 32'hDEADAAEF) begin errors++; $display("FAIL core_b2b0 got=%h exp=deadaaef", dat_rd); end
    dat_a = 16'h0020;
    @(negedge clk);
    checks++; if (dat_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL core_b2b1 got=%h exp=cafef00d", dat_rd); end
    dat_a = 16'h0050; dat_re = 4'b1100;
    @(negedge clk);
    checks++; if (dat_rd !== 32'h55550000) begin errors++; $display("FAIL core_b2b2 got=%h exp=55550000", dat_rd); end
    checks++; if (hst_rd !== 32'h5555AAAA) begin errors++; $display("FAIL hst_rd_hold got=%h exp=5555aaaa", hst_rd); end
    core_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic [31:0] rd;
    host_op(1'b1, 16'h0070, 32'h12121212, ack, rd);
    hst_req = 1'b1; hst_we = 1'b1; hst_a = 16'h0060; hst_wd = 32'h0BADF00D;
    @(negedge clk);
    checks++; if (hst_ack !== 1'b1) begin errors++; $display("FAIL rm_pre_ack got=%b exp=1", hst_ack); end
    rstn = 1'b0;
    hst_we = 1'b0;
    dat_a = 16'h0070; dat_we = 4'hF; dat_wd = 32'h77777777;
    @(negedge clk);
    checks++; if (hst_ack !== 1'b0) begin errors++; $display("FAIL rm_ack got=%b exp=0", hst_ack); end
    checks++; if (dat_rd !== 32'h0) begin errors++; $display("FAIL rm_dat_rd got=%h exp=0", dat_rd); end
    checks++; if (hst_rd !== 32'h0) begin errors++; $display("FAIL rm_hst_rd got=%h exp=0", hst_rd); end
    @(negedge clk);
    checks++; if (hst_ack !== 1'b0) begin errors++; $display("FAIL rm_ack2 got=%b exp=0", hst_ack); end
    hst_req = 1'b0;
    core_idle();
    rstn = 1'b1;
    @(negedge clk);
    host_op(1'b0, 16'h0060, 32'h0, ack, rd);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rm_keep got=%h exp=0badf00d", rd); end
    host_op(1'b0, 16'h0070, 32'h0, ack, rd);
    checks++; if (rd !== 32'h12121212) begin errors++; $display("FAIL rm_drop got=%h exp=12121212", rd); end
  endtask

`ifdef DMEM_RESP_PARITY_EN
  task automatic test_parity();
    logic ack;
    logic [31:0] rd;
    host_op(1'b1, 16'h0030, 32'h000000A5, ack, rd);
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clean got=%b exp=0", par_err); end
    u_dut.u_bank.mem_q[48] = u_dut.u_bank.mem_q[48] ^ 32'h1;
    dat_a = 16'h0030; dat_re = 4'b0001;
    @(negedge clk);
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_set got=%b exp=1", par_err); end
    core_idle();
    repeat (2) @(negedge clk);
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_sticky got=%b exp=1", par_err); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clear got=%b exp=0", par_err); end
  endtask
`endif

  initial begin
    rstn = 1'b0;
    dat_a = 16'h0;
    core_idle();
    hst_req = 1'b0;
    hst_we = 1'b0;
    hst_a = 16'h0;
    hst_wd = 32'h0;
    test_reset();
    test_host();
    test_core_lanes();
    test_rbw();
    test_alias();
    test_host_wait();
    test_back_to_back();
    test_reset_mid();
`ifdef DMEM_RESP_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
